// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit path: handshake states,
// read/write encoding for spart_control and the native word width.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } spart_state_t;

    localparam logic SPART_WR     = 1'b0;
    localparam logic SPART_RD     = 1'b1;
    localparam int   SPART_WORD_W = 24;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with separate occupancy count.
// Writes into a full FIFO are accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop_ok;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push    = wr_en && (!full || pop_ok);
    assign drop    = wr_en && full && !pop_ok;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; only words covered by count are ever read out
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/spart_tx_queue.sv
// Transmit queue feeding spart_control: buffers host words and offers them
// one at a time on the chip_enable/ack handshake, popping only on ack.
import spart_pkg::*;

module spart_tx_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = SPART_WORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     chip_enable,
    output logic                     r_w,
    output logic [WIDTH-1:0]         tx_data,
    input  logic                     ack
);
    spart_state_t     state;
    spart_state_t     state_nxt;
    logic             load;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .drop    (drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // GAP sees the post-pop count and head, so a word pushed alongside the last pop is still offered
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    pop       = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (count != '0) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                tx_data <= head;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign chip_enable = (state == REQ);
    assign r_w         = SPART_WR;

endmodule

// File: tb/tb_spart_tx_queue.sv
// Directed self-checking bench for spart_tx_queue (DEPTH=4, WIDTH=24).
module tb_spart_tx_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [23:0] wr_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        chip_enable;
    logic        r_w;
    logic [23:0] tx_data;
    logic        ack;

    int n_chk  = 0;
    int n_fail = 0;

    spart_tx_queue #(
        .DEPTH (4),
        .WIDTH (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .chip_enable (chip_enable),
        .r_w         (r_w),
        .tx_data     (tx_data),
        .ack         (ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [23:0] exp4 [4];

    initial begin
        // Reset held with strobes active
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 24'h123456;
        ack     = 1'b1;
        repeat (3) tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_ce", 32'(chip_enable), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_r_w", 32'(r_w), 0);
        rst_n = 1'b1;
        wr_en = 1'b0;
        ack   = 1'b0;
        tick();
        chk("post_rst_count", 32'(count), 0);

        // Single word: offered two cycles after the write
        wr_en   = 1'b1;
        wr_data = 24'hFEEDED;
        tick();
        wr_en = 1'b0;
        chk("single_count", 32'(count), 1);
        chk("single_empty", 32'(empty), 0);
        chk("single_ce_lat1", 32'(chip_enable), 0);
        tick();
        chk("single_ce", 32'(chip_enable), 1);
        chk("single_tx", 32'(tx_data), 32'hFEEDED);
        repeat (3) tick();
        chk("single_ce_hold", 32'(chip_enable), 1);
        chk("single_tx_hold", 32'(tx_data), 32'hFEEDED);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("single_ack_ce", 32'(chip_enable), 0);
        chk("single_ack_count", 32'(count), 0);
        chk("single_ack_empty", 32'(empty), 1);
        tick();
        chk("single_idle_ce", 32'(chip_enable), 0);

        // Stray ack in IDLE
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("stray_idle_count", 32'(count), 0);
        chk("stray_idle_ce", 32'(chip_enable), 0);
        tick();
        chk("stray_idle_ce2", 32'(chip_enable), 0);

        // Fill to DEPTH and overflow with word 5
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 24'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_ce", 32'(chip_enable), 1);
        // Held ack: one pop per two cycles, ack in GAP ignored
        ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_ce", 32'(chip_enable), 1);
            chk("drain_tx", 32'(tx_data), 32'(k));
            tick();
            chk("drain_gap_ce", 32'(chip_enable), 0);
            chk("drain_gap_count", 32'(count), 32'(4 - k));
            tick();
        end
        ack = 1'b0;
        tick();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_ce_idle", 32'(chip_enable), 0);
        chk("drain_no_word5", 32'(tx_data), 4);
        chk("drain_overflow_sticky", 32'(overflow), 1);

        // Reset to clear overflow, then simultaneous push and pop when full
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("clr_overflow", 32'(overflow), 0);
        exp4[0] = 24'h000022;
        exp4[1] = 24'h000033;
        exp4[2] = 24'h000044;
        exp4[3] = 24'h0000AA;
        wr_en = 1'b1;
        wr_data = 24'h11; tick();
        wr_data = 24'h22; tick();
        wr_data = 24'h33; tick();
        wr_data = 24'h44; tick();
        chk("pp_full", 32'(full), 1);
        chk("pp_ce", 32'(chip_enable), 1);
        chk("pp_tx", 32'(tx_data), 32'h11);
        wr_data = 24'hAA;
        ack     = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("pp_count", 32'(count), 4);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_gap_ce", 32'(chip_enable), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("pp_drain_ce", 32'(chip_enable), 1);
            chk("pp_drain_tx", 32'(tx_data), 32'(exp4[k]));
            tick();
            chk("pp_drain_count", 32'(count), 32'(3 - k));
        end
        tick();
        ack = 1'b0;
        chk("pp_empty", 32'(empty), 1);
        chk("pp_ce_idle", 32'(chip_enable), 0);

        // Reset during REQ with three words queued
        wr_en = 1'b1;
        wr_data = 24'h000101; tick();
        wr_data = 24'h000202; tick();
        wr_data = 24'h000303; tick();
        wr_en = 1'b0;
        chk("mid_count", 32'(count), 3);
        chk("mid_ce", 32'(chip_enable), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_ce", 32'(chip_enable), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_tx", 32'(tx_data), 0);
        wr_en   = 1'b1;
        wr_data = 24'h00BEEF;
        tick();
        wr_en = 1'b0;
        chk("after_rst_lat1", 32'(chip_enable), 0);
        chk("after_rst_count", 32'(count), 1);
        tick();
        chk("after_rst_ce", 32'(chip_enable), 1);
        chk("after_rst_tx", 32'(tx_data), 32'h00BEEF);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("after_rst_pop_count", 32'(count), 0);
        chk("after_rst_pop_ce", 32'(chip_enable), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
